axi_pt_mem_chip: RTL and testbench

// - Self-contained AXI4-Lite test chip. An internal master writes a known pattern, reads it back and scores it.
// - A passthrough monitor counts handshakes. A memory-model slave answers all requests.
// - Top-level block of the VIP example design. Drives nothing off-chip except status outputs.

---
 rtl/axi_pt_mem_chip.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_pt_mem_chip.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_pt_mem_chip.sv
// AXI4-Lite self-test chip: internal master writes/reads a pattern against a memory-model slave, with a passive handshake monitor.
// Define AXI_PT_MEM_STALL_EN to let an LFSR stall the slave's READY and response timing.
module axi_pt_mem_chip #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MEM_DEPTH = 256,
    parameter int unsigned       NUM_XFERS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = (NUM_XFERS > 1) ? $clog2(NUM_XFERS) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [DATA_W-1:0] PATTERN = DATA_W'(32'hA5A5_0000);

    typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RSP, S_RD_REQ, S_RD_RSP, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]        err_q, err_d, wr_q, wr_d, rd_q, rd_d;
    logic               rdy_en_q;
    logic               aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               b_pend_q, b_pend_d, r_pend_q, r_pend_d;
    logic [1:0]         b_dly_q, b_dly_d, r_dly_q, r_dly_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  mem [MEM_DEPTH];

    logic               stall_ok;
    logic [1:0]         rsp_dly;

    // Master-slave AXI4-Lite bus (the monitor taps these)
    logic               m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready;
    logic               m_arvalid, s_arready, s_rvalid, m_rready;
    logic [ADDR_W-1:0]  m_awaddr, m_araddr, wr_addr;
    logic [DATA_W-1:0]  m_wdata, s_rdata, wr_data;
    logic [STRB_W-1:0]  m_wstrb, wr_strb;
    logic [1:0]         s_bresp, s_rresp;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs, slave_idle, mem_we;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic [1:0]         err_inc;
    logic [16:0]        err_sum;

`ifdef AXI_PT_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall_ok = lfsr_q[0];
    assign rsp_dly  = lfsr_q[2:1];
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr_q <= 8'hA5;
        else          lfsr_q <= lfsr_d;
    end
`else
    assign stall_ok = 1'b1;
    assign rsp_dly  = 2'd0;
`endif

    assign m_awvalid = awvalid_q;
    assign m_awaddr  = BASE_ADDR + (ADDR_W'(xfer_q) << 2);
    assign m_wvalid  = wvalid_q;
    assign m_wdata   = PATTERN | DATA_W'(xfer_q);
    assign m_wstrb   = '1;
    assign m_bready  = (state_q == S_WR_RSP);
    assign m_arvalid = arvalid_q;
    assign m_araddr  = m_awaddr;
    assign m_rready  = (state_q == S_RD_RSP);

    // READY is held low through reset and while a response is outstanding
    assign slave_idle = rdy_en_q && !b_pend_q && !r_pend_q;
    assign s_awready  = slave_idle && !aw_got_q && stall_ok;
    assign s_wready   = slave_idle && !w_got_q && stall_ok;
    assign s_arready  = slave_idle && !aw_got_q && !w_got_q && stall_ok;
    assign s_bvalid   = b_pend_q && (b_dly_q == 2'd0);
    assign s_bresp    = OKAY;
    assign s_rvalid   = r_pend_q && (r_dly_q == 2'd0);
    assign s_rdata    = rdata_q;
    assign s_rresp    = OKAY;

    assign aw_hs = m_awvalid && s_awready;
    assign w_hs  = m_wvalid && s_wready;
    assign b_hs  = s_bvalid && m_bready;
    assign ar_hs = m_arvalid && s_arready;
    assign r_hs  = s_rvalid && m_rready;

    assign wr_addr = aw_got_q ? awaddr_q : m_awaddr;
    assign wr_data = w_got_q ? wdata_q : m_wdata;
    assign wr_strb = w_got_q ? wstrb_q : m_wstrb;
    assign wr_idx  = wr_addr[2 +: IDX_W];
    assign rd_idx  = m_araddr[2 +: IDX_W];
    assign mem_we  = (aw_got_q || aw_hs) && (w_got_q || w_hs) && (aw_hs || w_hs);

    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        b_pend_d = b_pend_q;
        b_dly_d  = b_dly_q;
        r_pend_d = r_pend_q;
        r_dly_d  = r_dly_q;
        rdata_d  = rdata_q;
        if (aw_hs) begin
            aw_got_d = 1'b1;
            awaddr_d = m_awaddr;
        end
        if (w_hs) begin
            w_got_d = 1'b1;
            wdata_d = m_wdata;
            wstrb_d = m_wstrb;
        end
        if (mem_we) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            b_pend_d = 1'b1;
            b_dly_d  = rsp_dly;
        end
        if (b_pend_q) begin
            if (b_dly_q != 2'd0) b_dly_d = b_dly_q - 2'd1;
            else if (b_hs)       b_pend_d = 1'b0;
        end
        if (ar_hs) begin
            r_pend_d = 1'b1;
            r_dly_d  = rsp_dly;
            rdata_d  = mem[rd_idx];
        end
        if (r_pend_q) begin
            if (r_dly_q != 2'd0) r_dly_d = r_dly_q - 2'd1;
            else if (r_hs)       r_pend_d = 1'b0;
        end
    end

    assign err_inc = 2'(b_hs && (s_bresp != OKAY)) + 2'(r_hs && (s_rresp != OKAY))
                   + 2'(r_hs && (s_rdata != m_wdata));
    assign err_sum = {1'b0, err_q} + 17'(err_inc);

    always_comb begin
        state_d   = state_q;
        xfer_d    = xfer_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        wr_d      = wr_q + 16'(aw_hs);
        rd_d      = rd_q + 16'(r_hs);
        err_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_WR_REQ;
                xfer_d    = '0;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                err_d     = '0;
                wr_d      = '0;
                rd_d      = '0;
            end
            S_WR_REQ: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = S_WR_RSP;
            end
            S_WR_RSP: if (b_hs) begin
                if (xfer_q == CNT_W'(NUM_XFERS - 1)) begin
                    xfer_d    = '0;
                    state_d   = S_RD_REQ;
                    arvalid_d = 1'b1;
                end else begin
                    xfer_d    = xfer_q + CNT_W'(1);
                    state_d   = S_WR_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            S_RD_REQ: if (ar_hs) begin
                arvalid_d = 1'b0;
                state_d   = S_RD_RSP;
            end
            S_RD_RSP: if (r_hs) begin
                if (xfer_q == CNT_W'(NUM_XFERS - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    xfer_d    = xfer_q + CNT_W'(1);
                    state_d   = S_RD_REQ;
                    arvalid_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            xfer_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            rdy_en_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            b_pend_q  <= 1'b0;
            b_dly_q   <= '0;
            r_pend_q  <= 1'b0;
            r_dly_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            xfer_q    <= xfer_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rdy_en_q  <= 1'b1;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            b_pend_q  <= b_pend_d;
            b_dly_q   <= b_dly_d;
            r_pend_q  <= r_pend_d;
            r_dly_q   <= r_dly_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign wr_cnt  = wr_q;
    assign rd_cnt  = rd_q;
endmodule

// File: tb/tb_axi_pt_mem_chip.sv
// Bench for axi_pt_mem_chip: three configurations checked against an array-based memory model.
module tb_axi_pt_mem_chip;
    localparam int NDUT = 3;
`ifdef AXI_PT_MEM_STALL_EN
    localparam int STALL = 1;
`else
    localparam int STALL = 0;
`endif

    typedef struct {
        int k;
        int extra_at;
        int exp_wr;
        int exp_rd;
        int exp_err;
        int exp_pass;
    } vec_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [NDUT-1:0] start_i = '0;
    logic [NDUT-1:0] busy_o, done_o, pass_o;
    logic [15:0] err_o [NDUT];
    logic [15:0] wr_o [NDUT];
    logic [15:0] rd_o [NDUT];

    int total = 0;
    int passed = 0;
    int viol = 0;
    int aw_seen0 = 0;

    always #5 aclk = ~aclk;

    axi_pt_mem_chip #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .NUM_XFERS(16), .BASE_ADDR(32'h0))
    dut0 (.aclk(aclk), .aresetn(aresetn), .start(start_i[0]), .busy(busy_o[0]), .done(done_o[0]),
          .pass(pass_o[0]), .err_cnt(err_o[0]), .wr_cnt(wr_o[0]), .rd_cnt(rd_o[0]));
    axi_pt_mem_chip #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(8), .NUM_XFERS(16), .BASE_ADDR(32'h0))
    dut1 (.aclk(aclk), .aresetn(aresetn), .start(start_i[1]), .busy(busy_o[1]), .done(done_o[1]),
          .pass(pass_o[1]), .err_cnt(err_o[1]), .wr_cnt(wr_o[1]), .rd_cnt(rd_o[1]));
    axi_pt_mem_chip #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(4), .NUM_XFERS(6), .BASE_ADDR(32'h108))
    dut2 (.aclk(aclk), .aresetn(aresetn), .start(start_i[2]), .busy(busy_o[2]), .done(done_o[2]),
          .pass(pass_o[2]), .err_cnt(err_o[2]), .wr_cnt(wr_o[2]), .rd_cnt(rd_o[2]));

    function automatic int dep(int k);
        return (k == 0) ? 256 : (k == 1) ? 8 : 4;
    endfunction
    function automatic int nx(int k);
        return (k == 2) ? 6 : 16;
    endfunction
    function automatic int unsigned base(int k);
        return (k == 2) ? 32'h108 : 32'h0;
    endfunction

    // Final memory image after all writes, then score every read against its own pattern
    function automatic int model_err(int k);
        int unsigned mem [256];
        int unsigned idx;
        int e = 0;
        for (int i = 0; i < nx(k); i++) begin
            idx = ((base(k) + 4 * i) / 4) % dep(k);
            mem[idx] = 32'hA5A5_0000 | i;
        end
        for (int i = 0; i < nx(k); i++) begin
            idx = ((base(k) + 4 * i) / 4) % dep(k);
            if (mem[idx] != (32'hA5A5_0000 | i)) e++;
        end
        return e;
    endfunction

    function automatic vec_t mk(int k, int extra_at);
        vec_t v;
        v.k = k;
        v.extra_at = extra_at;
        v.exp_wr = nx(k);
        v.exp_rd = nx(k);
        v.exp_err = model_err(k);
        v.exp_pass = (v.exp_err == 0) ? 1 : 0;
        return v;
    endfunction

    task automatic check(string name, longint unsigned got, longint unsigned exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic run_row(vec_t v);
        int k;
        int cyc;
        int lim;
        int aw0;
        k = v.k;
        lim = STALL ? 4000 : 4 * nx(k) + 4;
        aw0 = aw_seen0;
        start_i[k] = 1'b1;
        @(negedge aclk);
        start_i[k] = 1'b0;
        check($sformatf("busy_after_start[%0d]", k), busy_o[k], 1);
        check($sformatf("done_cleared[%0d]", k), done_o[k], 0);
        cyc = 1;
        while (!done_o[k] && cyc < lim) begin
            start_i[k] = (cyc == v.extra_at);
            @(negedge aclk);
            cyc++;
        end
        start_i[k] = 1'b0;
        check($sformatf("done_in_budget[%0d]", k), done_o[k], 1);
        check($sformatf("err_cnt[%0d]", k), err_o[k], v.exp_err);
        check($sformatf("wr_cnt[%0d]", k), wr_o[k], v.exp_wr);
        check($sformatf("rd_cnt[%0d]", k), rd_o[k], v.exp_rd);
        check($sformatf("pass[%0d]", k), pass_o[k], v.exp_pass);
        if (k == 0) check("aw_handshakes_one_run", aw_seen0 - aw0, nx(0));
        // state is DONE here: a start now must not launch a run
        start_i[k] = 1'b1;
        @(negedge aclk);
        start_i[k] = 1'b0;
        check($sformatf("start_at_done_ignored[%0d]", k), busy_o[k], 0);
        check($sformatf("done_held[%0d]", k), done_o[k], 1);
        repeat (3) @(negedge aclk);
        check($sformatf("stays_idle[%0d]", k), {busy_o[k], done_o[k], wr_o[k]}, {1'b0, 1'b1, 16'(v.exp_wr)});
    endtask

    task automatic reset_and_check(int k);
        #2 aresetn = 1'b0;
        #1 check($sformatf("async_reset_outputs[%0d]", k),
                 {busy_o[k], done_o[k], pass_o[k], err_o[k], wr_o[k], rd_o[k]}, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    // Protocol stability on dut0's internal bus: once VALID is up without READY it must hold
    logic p_aw = 0, p_w = 0, p_ar = 0, p_b = 0, p_r = 0;
    logic [31:0] h_aw, h_w, h_ar, h_r;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0; p_b <= 1'b0; p_r <= 1'b0;
        end else begin
            viol <= viol
                + int'(p_aw && (!dut0.m_awvalid || dut0.m_awaddr != h_aw))
                + int'(p_w  && (!dut0.m_wvalid  || dut0.m_wdata  != h_w))
                + int'(p_ar && (!dut0.m_arvalid || dut0.m_araddr != h_ar))
                + int'(p_b  && !dut0.s_bvalid)
                + int'(p_r  && (!dut0.s_rvalid  || dut0.s_rdata  != h_r));
            p_aw <= dut0.m_awvalid && !dut0.s_awready;
            p_w  <= dut0.m_wvalid  && !dut0.s_wready;
            p_ar <= dut0.m_arvalid && !dut0.s_arready;
            p_b  <= dut0.s_bvalid  && !dut0.m_bready;
            p_r  <= dut0.s_rvalid  && !dut0.m_rready;
            h_aw <= dut0.m_awaddr;
            h_w  <= dut0.m_wdata;
            h_ar <= dut0.m_araddr;
            h_r  <= dut0.s_rdata;
        end
    end

    always @(posedge aclk) begin
        if (dut0.m_awvalid && dut0.s_awready) aw_seen0 <= aw_seen0 + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int nz;
        int k;
        int rc;
        tbl[0] = mk(0, -1);
        tbl[1] = mk(0, 5);
        tbl[2] = mk(0, 40);
        tbl[3] = mk(1, -1);
        tbl[4] = mk(2, -1);
        tbl[5] = mk(2, 3);

        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        nz = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            for (int d = 0; d < NDUT; d++)
                if (busy_o[d] || done_o[d] || pass_o[d] || err_o[d] != 0 || wr_o[d] != 0 || rd_o[d] != 0) nz++;
        end
        check("idle_outputs_zero", nz, 0);

        for (int i = 0; i < 6; i++) run_row(tbl[i]);

        // Reset at cycle 20 of a run, then a clean run
        start_i[0] = 1'b1;
        @(negedge aclk);
        start_i[0] = 1'b0;
        repeat (19) @(negedge aclk);
        reset_and_check(0);
        run_row(tbl[0]);

        for (int it = 0; it < 6; it++) begin
            k = int'($urandom_range(0, NDUT - 1));
            rc = int'($urandom_range(2, 4 * nx(k)));
            start_i[k] = 1'b1;
            @(negedge aclk);
            start_i[k] = 1'b0;
            for (int c = 1; c < rc; c++) begin
                start_i[k] = busy_o[k] && ($urandom_range(0, 5) == 0);
                @(negedge aclk);
            end
            start_i[k] = 1'b0;
            reset_and_check(k);
            run_row(mk(k, -1));
        end

        check("axi_valid_payload_stability", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
